// File: rtl/fp_wb_nanbox_if.sv
// Upstream result and register-file writeback handshake bundle for fp_wb_nanbox.
//   in_*  : completed FP result from the converter/ALU units (valid/ready)
//   wb_*  : boxed result presented to the FP register file (valid/ready)
// The slave modport is the writeback stage; the master modport drives results and accepts writebacks.
interface fp_wb_nanbox_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_fmt;
  logic [63:0] in_data;
  logic [4:0]  in_rd;
  logic [4:0]  in_flags;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;

  modport slave (
    input  in_valid, in_fmt, in_data, in_rd, in_flags, wb_ready,
    output in_ready, wb_valid, wb_data, wb_rd
  );

  modport master (
    output in_valid, in_fmt, in_data, in_rd, in_flags, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_rd
  );
endinterface

// File: rtl/fp_wb_nanbox.sv
// FP writeback stage: buffers completed results in a DEPTH-entry FIFO, NaN-boxes
// single-precision values into the 64-bit register format, and accumulates sticky fflags.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : fp_wb_nanbox_if.slave (in_* result input, wb_* writeback output)
//   fflags_clr  : clear accumulated flags (CSR write)
//   fflags      : sticky accumulated exception flags {NV,DZ,OF,UF,NX}
// Optional macro FP_WB_CANON_NAN_EN: replace NaN results with the RISC-V canonical NaN.
module fp_wb_nanbox #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_wb_nanbox_if.slave  bus,
  input  logic           fflags_clr,
  output logic [4:0]     fflags
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic [4:0]  flags;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        fflags_q, fflags_d;
  logic [63:0]       boxed_data;
  logic              push, pop;
  entry_t            head;

  assign push = bus.in_valid && in_ready_q;
  assign pop  = wb_valid_q && bus.wb_ready;
  assign head = mem_q[rd_ptr_q];

  // Format the incoming result into the 64-bit register layout.
  always_comb begin
    boxed_data = bus.in_fmt ? bus.in_data : {32'hFFFF_FFFF, bus.in_data[31:0]};
`ifdef FP_WB_CANON_NAN_EN
    if (!bus.in_fmt && (bus.in_data[30:23] == 8'hFF) && (bus.in_data[22:0] != 23'd0)) begin
      boxed_data = 64'hFFFF_FFFF_7FC0_0000;
    end
    if (bus.in_fmt && (bus.in_data[62:52] == 11'h7FF) && (bus.in_data[51:0] != 52'd0)) begin
      boxed_data = 64'h7FF8_0000_0000_0000;
    end
`endif
  end

  // Next-state for pointers, occupancy, handshake flags and sticky fflags.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    fflags_d = fflags_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    // Clear takes effect before the popped flags are merged, so they survive.
    if (fflags_clr) fflags_d = 5'd0;
    if (pop)        fflags_d = fflags_d | head.flags;
    in_ready_d = (count_d != CNT_W'(DEPTH));
    wb_valid_d = (count_d != CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fflags_q   <= '0;
      in_ready_q <= 1'b1;
      wb_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fflags_q   <= fflags_d;
      in_ready_q <= in_ready_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  // Storage has no reset; only entries covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{data: boxed_data, rd: bus.in_rd, flags: bus.in_flags};
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data  = head.data;
  assign bus.wb_rd    = head.rd;
  assign fflags       = fflags_q;

endmodule

// File: tb/tb_fp_wb_nanbox.sv
// Self-checking bench for fp_wb_nanbox: table of single push/pop vectors plus
// directed sequences for backpressure, wrap, flag clear and reset mid-operation.
module tb_fp_wb_nanbox;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fflags_clr;
  logic [4:0] fflags;
  int         n_vec = 0;
  int         n_err = 0;

  fp_wb_nanbox_if bus ();

  fp_wb_nanbox #(.DEPTH(2), .PTR_W(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fflags_clr (fflags_clr),
    .fflags     (fflags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fmt;
    logic [63:0] data;
    logic [4:0]  rd;
    logic [4:0]  flags;
    logic        clr;
    logic [63:0] exp_data;
    logic [4:0]  exp_fflags;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [63:0] nan_s_exp;
    logic [63:0] nan_d_exp;
`ifdef FP_WB_CANON_NAN_EN
    nan_s_exp = 64'hFFFF_FFFF_7FC0_0000;
    nan_d_exp = 64'h7FF8_0000_0000_0000;
`else
    nan_s_exp = 64'hFFFF_FFFF_FFA0_0001;
    nan_d_exp = 64'h7FF0_0000_0000_0001;
`endif
    //            fmt   data                    rd     flags     clr   exp_data                fflags after pop
    vecs[0] = '{1'b0, 64'h0123_4567_3F80_0000, 5'd3,  5'b00000, 1'b0, 64'hFFFF_FFFF_3F80_0000, 5'b00000};
    vecs[1] = '{1'b1, 64'h4009_21FB_5444_2D18, 5'd7,  5'b00001, 1'b0, 64'h4009_21FB_5444_2D18, 5'b00001};
    vecs[2] = '{1'b0, 64'h0000_0000_FFA0_0001, 5'd1,  5'b00000, 1'b0, nan_s_exp,               5'b00001};
    vecs[3] = '{1'b0, 64'h0000_0000_0000_0000, 5'd2,  5'b10000, 1'b1, 64'hFFFF_FFFF_0000_0000, 5'b10000};
    vecs[4] = '{1'b0, 64'h1111_1111_4000_0000, 5'd4,  5'b00100, 1'b1, 64'hFFFF_FFFF_4000_0000, 5'b00100};
    vecs[5] = '{1'b1, 64'h7FF0_0000_0000_0001, 5'd31, 5'b01000, 1'b0, nan_d_exp,               5'b01100};
    vecs[6] = '{1'b0, 64'hDEAD_BEEF_7F80_0000, 5'd9,  5'b00010, 1'b0, 64'hFFFF_FFFF_7F80_0000, 5'b01110};

    rst_n        = 1'b0;
    fflags_clr   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_fmt   = 1'b0;
    bus.in_data  = '0;
    bus.in_rd    = '0;
    bus.in_flags = '0;
    bus.wb_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("reset_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_fflags",   64'(fflags),       64'd0);

    // Table: push one result, inspect it buffered, then pop it (optionally with clear).
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_fmt   = vecs[i].fmt;
      bus.in_data  = vecs[i].data;
      bus.in_rd    = vecs[i].rd;
      bus.in_flags = vecs[i].flags;
      step();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_wb_valid", i), 64'(bus.wb_valid), 64'd1);
      chk($sformatf("v%0d_wb_data", i),  bus.wb_data,       vecs[i].exp_data);
      chk($sformatf("v%0d_wb_rd", i),    64'(bus.wb_rd),    64'(vecs[i].rd));
      bus.wb_ready = 1'b1;
      fflags_clr   = vecs[i].clr;
      step();
      bus.wb_ready = 1'b0;
      fflags_clr   = 1'b0;
      chk($sformatf("v%0d_fflags", i),    64'(fflags),       64'(vecs[i].exp_fflags));
      chk($sformatf("v%0d_drained", i),   64'(bus.wb_valid), 64'd0);
    end

    // Clear with no pop.
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    chk("clr_alone", 64'(fflags), 64'd0);

    // Backpressure: fill two entries, hold a third, then drain in order.
    bus.in_fmt   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hA;
    bus.in_rd    = 5'd10;
    bus.in_flags = 5'b10000;
    step();
    chk("bp_ready_after1", 64'(bus.in_ready), 64'd1);
    chk("bp_flags_hidden", 64'(fflags),       64'd0);
    bus.in_data  = 64'hB;
    bus.in_rd    = 5'd11;
    bus.in_flags = 5'b00000;
    step();
    chk("bp_full", 64'(bus.in_ready), 64'd0);
    bus.in_data = 64'hC;
    bus.in_rd   = 5'd12;
    step();
    chk("bp_still_full", 64'(bus.in_ready), 64'd0);
    chk("bp_head_rd",    64'(bus.wb_rd),    64'd10);
    chk("bp_head_data",  bus.wb_data,       64'hFFFF_FFFF_0000_000A);
    bus.wb_ready = 1'b1;
    step();
    chk("bp_pop1_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_pop1_rd",    64'(bus.wb_rd),    64'd11);
    chk("bp_pop1_flags", 64'(fflags),       64'b10000);
    step();
    bus.in_valid = 1'b0;
    chk("bp_pop2_rd",    64'(bus.wb_rd),    64'd12);
    chk("bp_pop2_valid", 64'(bus.wb_valid), 64'd1);
    chk("bp_pop2_data",  bus.wb_data,       64'hFFFF_FFFF_0000_000C);
    step();
    bus.wb_ready = 1'b0;
    chk("bp_empty", 64'(bus.wb_valid), 64'd0);

    // Pointer wrap: back-to-back push/pop, occupancy stays at one.
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_rd    = 5'(i);
      bus.in_data  = 64'(i);
      step();
      chk($sformatf("wrap%0d_rd", i),    64'(bus.wb_rd),    64'(i));
      chk($sformatf("wrap%0d_data", i),  bus.wb_data,       {32'hFFFF_FFFF, 32'(i)});
      chk($sformatf("wrap%0d_ready", i), 64'(bus.in_ready), 64'd1);
    end
    bus.in_valid = 1'b0;
    step();
    bus.wb_ready = 1'b0;
    chk("wrap_empty", 64'(bus.wb_valid), 64'd0);

    // Reset with buffered entries discards them and clears fflags.
    bus.in_valid = 1'b1;
    bus.in_flags = 5'b00011;
    step();
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mid_valid",  64'(bus.wb_valid), 64'd0);
    chk("rst_mid_ready",  64'(bus.in_ready), 64'd1);
    chk("rst_mid_fflags", 64'(fflags),       64'd0);
    step();
    chk("rst_mid_stay",   64'(bus.wb_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_wb_nanbox.md
Name: fp_wb_nanbox

Overview:
- Writeback stage directly downstream of the double-to-single converter and the other D-extension ALU units.
- Buffers completed FP results in a small FIFO, NaN-boxes single-precision results into the 64-bit FP register format, and presents them to the FP register file over a valid/ready handshake.
- Keeps the sticky accumulated exception flags (fflags) that feed fcsr.

Parameters:
- DEPTH, 2: FIFO entries; power of two, minimum 2.
- PTR_W, 1: pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- rst_n  in  1  Synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  Upstream result valid.
- in_ready  out  1  Stage can accept a result.
- in_fmt  in  1  Result format: 0 = single (data in in_data[31:0]), 1 = double.
- in_data  in  64  Result value; bits [63:32] are ignored when in_fmt = 0.
- in_rd  in  5  Destination FP register index.
- in_flags  in  5  Exception flags {NV,DZ,OF,UF,NX} raised by this result.
- wb_valid  out  1  Writeback entry valid.
- wb_ready  in  1  Register file accepts the writeback.
- wb_data  out  64  Boxed 64-bit value.
- wb_rd  out  5  Destination register index.
- fflags_clr  in  1  Clear the accumulated flags (CSR write of fflags/fcsr).
- fflags  out  5  Sticky accumulated flags.

Behaviour:
- Reset (rst_n = 0 at a clock edge): read pointer, write pointer and count go to 0; fflags = 0; wb_valid = 0. Storage contents are don't-care. in_ready reads 1 in the cycle after reset.
- Push: occurs when in_valid && in_ready. The entry stores {boxed_data, in_rd, in_flags}.
  - Boxing for in_fmt = 0: boxed_data = {32'hFFFF_FFFF, in_data[31:0]}.
  - For in_fmt = 1: boxed_data = in_data.
- Pop: occurs when wb_valid && wb_ready.
- Full and empty:
  - in_ready = (count != DEPTH). It is registered-state only, with no combinational path from wb_ready.
  - wb_valid = (count != 0).
  - wb_data and wb_rd show the entry at the read pointer. They hold steady while wb_valid && !wb_ready.
- Latency: a result pushed at edge N is visible on wb_valid/wb_data after edge N. The FIFO has no bypass: minimum 1 cycle.
- Simultaneous push and pop: both pointers advance and count is unchanged.
  - When full, a push is refused even if a pop happens in the same cycle. in_ready is 0 and upstream must hold its data.
- Pointer wrap: pointers increment modulo DEPTH, and wrap DEPTH-1 -> 0 silently. count ranges 0..DEPTH.
- Flag accumulation:
  - On each pop: fflags <= fflags | entry_flags.
  - On fflags_clr alone: fflags <= 0.
  - fflags_clr and a pop in the same cycle: fflags <= entry_flags. The clear is applied first and the popped flags survive.
  - Flags of entries still in the FIFO are never visible on fflags.
- Upstream protocol: upstream must hold in_* stable while in_valid && !in_ready. The block does not check this.
- Reset mid-operation: all buffered entries are discarded, no partial writeback occurs, and fflags is cleared.

Optional Feature:
- Macro: FP_WB_CANON_NAN_EN.
- Defined: for in_fmt = 0 with in_data[30:23] = 8'hFF and in_data[22:0] != 0 (single NaN), the stored value becomes 64'hFFFF_FFFF_7FC0_0000. The sign and payload are dropped (RISC-V canonical NaN). For in_fmt = 1 with in_data[62:52] = 11'h7FF and fraction != 0, the stored value becomes 64'h7FF8_0000_0000_0000.
- Undefined: NaN payloads pass through unchanged, boxed as described above.

Test Plan:
- Reset then single push: in_fmt = 0, in_data = 64'h0123_4567_3F80_0000, rd = 3, flags = 0, wb_ready = 1 -> next cycle wb_valid = 1, wb_data = 64'hFFFF_FFFF_3F80_0000, wb_rd = 3. Popped that cycle; fflags = 0.
- Double pass-through with flags: in_fmt = 1, in_data = 64'h4009_21FB_5444_2D18, flags = 5'b00001 -> wb_data equals the input. After the pop, fflags = 5'b00001.
- Backpressure and full: wb_ready = 0, push 3 results -> in_ready = 0 after 2 pushes and the third is held. wb_data stays on entry 0. Raise wb_ready -> entries drain in order 0, 1, 2 and the third is accepted the cycle after the first pop.
- Simultaneous clear and pop: fflags = 5'b10000, then pop an entry with flags 5'b00100 while fflags_clr = 1 -> fflags = 5'b00100.
- Pointer wrap: 10 back-to-back push/pop pairs with rd = 0..9 -> outputs appear in order with no loss or duplication, and count never exceeds 2.
- NaN with FP_WB_CANON_NAN_EN defined: single input 32'hFFA0_0001 -> wb_data = 64'hFFFF_FFFF_7FC0_0000. Undefined -> wb_data = 64'hFFFF_FFFF_FFA0_0001.
